// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU single-port SRAM arbiter.
// FSM state encodings, owner encoding and default starvation/timeout limits.
package mem_arbiter_pkg;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_LS = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and SRAM command/response signals around the arbiter.
// slave = arbiter side, master = requesters plus SRAM macro side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req_i;
    logic [AW-1:0]   if_addr_i;
    logic            if_flush_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [DW-1:0]   if_rdata_o;
    logic            if_err_o;

    logic            ls_req_i;
    logic            ls_we_i;
    logic [AW-1:0]   ls_addr_i;
    logic [DW-1:0]   ls_wdata_i;
    logic [DW/8-1:0] ls_be_i;
    logic            ls_gnt_o;
    logic            ls_rvalid_o;
    logic [DW-1:0]   ls_rdata_o;
    logic            ls_err_o;

    logic            sram_req_o;
    logic            sram_we_o;
    logic [AW-1:0]   sram_addr_o;
    logic [DW-1:0]   sram_wdata_o;
    logic [DW/8-1:0] sram_be_o;
    logic            sram_ack_i;
    logic [DW-1:0]   sram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        input  sram_ack_i, sram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o,
        output sram_ack_i, sram_rdata_i
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Access timeout timer: reloads on every grant, counts down while an access is waiting.
// expired is high in the TIMEOUT-th wait cycle after the grant.
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt;

    // Loading TIMEOUT-1 makes terminal count land on the TIMEOUT-th WAIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between fetch (IFU) and load/store (LSU) with starvation guard,
// bus timeout and flushed-fetch dropping. ARB_PERF_CNT_EN adds saturating stall counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_stall_o,
    output logic [31:0] perf_ls_stall_o
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state, state_n;
    owner_e        owner;
    logic [SW-1:0] starve_cnt;
    logic          drop;
    logic          ls_store;
    logic          slot, gnt_if, gnt_ls;
    logic          in_wait, expired, timeout_hit, done;
    logic          if_resp, ls_resp;

    assign in_wait     = (state != ARB_IDLE);
    assign slot        = !rst && (!in_wait || bus.sram_ack_i);
    assign timeout_hit = expired && !bus.sram_ack_i;
    assign done        = in_wait && (bus.sram_ack_i || expired);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        gnt_if  = 1'b0;
        gnt_ls  = 1'b0;
        owner   = OWN_LS;
        state_n = state;
        if (slot) begin
            if (bus.if_req_i && starve_cnt == SW'(STARVE_MAX)) begin
                gnt_if = 1'b1;
            end else if (bus.ls_req_i) begin
                gnt_ls = 1'b1;
            end else if (bus.if_req_i) begin
                gnt_if = 1'b1;
            end
        end
        if (gnt_if) owner = OWN_IF;
        if (gnt_if || gnt_ls) begin
            state_n = (owner == OWN_IF) ? ARB_WAIT_IF : ARB_WAIT_LS;
        end else if (done) begin
            state_n = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            drop       <= 1'b0;
            ls_store   <= 1'b0;
        end else begin
            if (!bus.if_req_i || gnt_if) begin
                starve_cnt <= '0;
            end else if (gnt_ls && starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            if (gnt_ls) ls_store <= bus.ls_we_i;
            // A flush alongside the grant marks the new fetch as dead from the start.
            if (gnt_if) begin
                drop <= bus.if_flush_i;
            end else if (gnt_ls || done) begin
                drop <= 1'b0;
            end else if (state == ARB_WAIT_IF && bus.if_flush_i) begin
                drop <= 1'b1;
            end
        end
    end

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (gnt_if || gnt_ls),
        .enable  (in_wait),
        .expired (expired)
    );

    assign bus.if_gnt_o     = gnt_if;
    assign bus.ls_gnt_o     = gnt_ls;
    assign bus.sram_req_o   = gnt_if || gnt_ls;
    assign bus.sram_we_o    = gnt_ls && bus.ls_we_i;
    assign bus.sram_addr_o  = gnt_ls ? bus.ls_addr_i : (gnt_if ? bus.if_addr_i : '0);
    assign bus.sram_wdata_o = gnt_ls ? bus.ls_wdata_i : '0;
    assign bus.sram_be_o    = gnt_ls ? bus.ls_be_i : (gnt_if ? '1 : '0);

    // A flush arriving in the completion cycle kills that response too.
    assign if_resp = (state == ARB_WAIT_IF) && done && !drop && !bus.if_flush_i;
    assign ls_resp = (state == ARB_WAIT_LS) && done;

    assign bus.if_rvalid_o = if_resp;
    assign bus.if_err_o    = if_resp && timeout_hit;
    assign bus.if_rdata_o  = (if_resp && !timeout_hit) ? bus.sram_rdata_i : '0;
    assign bus.ls_rvalid_o = ls_resp;
    assign bus.ls_err_o    = ls_resp && timeout_hit;
    assign bus.ls_rdata_o  = (ls_resp && !timeout_hit && !ls_store) ? bus.sram_rdata_i : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall_o <= '0;
            perf_ls_stall_o <= '0;
        end else begin
            if (bus.if_req_i && !gnt_if && perf_if_stall_o != '1) begin
                perf_if_stall_o <= perf_if_stall_o + 32'd1;
            end
            if (bus.ls_req_i && !gnt_ls && perf_ls_stall_o != '1) begin
                perf_ls_stall_o <= perf_ls_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: SRAM model with programmable latency plus response scoreboard.
// ARB_PERF_CNT_EN enables the stall-counter scenario.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 15;
    localparam int STV = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        logic        is_ls;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if, perf_ls;
`endif

    mem_arbiter #(.STARVE_MAX(STV), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall_o (perf_if),
        .perf_ls_stall_o (perf_ls)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sram_lat = 1;
    bit sram_mute = 1'b0;
    bit inject_ack = 1'b0;
    pend_t pend[$];
    exp_t  sb[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] pat(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // SRAM macro model: accepts a strobe, acks sram_lat cycles later.
    initial begin : sram_model
        pend_t p;
        bus.sram_ack_i   = 1'b0;
        bus.sram_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            bus.sram_ack_i   = 1'b0;
            bus.sram_rdata_i = '0;
            if (inject_ack) begin
                bus.sram_ack_i   = 1'b1;
                bus.sram_rdata_i = 32'hDEAD_BEEF;
                inject_ack       = 1'b0;
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                bus.sram_ack_i   = 1'b1;
                bus.sram_rdata_i = p.data;
            end
            @(negedge clk);
            if (bus.sram_req_o && !sram_mute) begin
                p.due = cyc + sram_lat;
                if (bus.sram_we_o) begin
                    mem[bus.sram_addr_o] = merge(mem_rd(bus.sram_addr_o), bus.sram_wdata_o, bus.sram_be_o);
                    p.data = 32'h0BAD_0BAD;
                end else begin
                    p.data = mem_rd(bus.sram_addr_o);
                end
                pend.push_back(p);
            end
        end
    end

    // Response scoreboard.
    initial begin : monitor
        exp_t e;
        logic [1:0] rv_exp;
        logic err_got;
        logic [31:0] data_got;
        forever begin
            @(negedge clk);
            if (bus.if_rvalid_o || bus.ls_rvalid_o) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d if_rvalid=%b ls_rvalid=%b", cyc, bus.if_rvalid_o, bus.ls_rvalid_o);
                end else begin
                    e = sb.pop_front();
                    rv_exp   = e.is_ls ? 2'b10 : 2'b01;
                    err_got  = e.is_ls ? bus.ls_err_o : bus.if_err_o;
                    data_got = e.is_ls ? bus.ls_rdata_o : bus.if_rdata_o;
                    if ({bus.ls_rvalid_o, bus.if_rvalid_o} !== rv_exp || err_got !== e.err ||
                        data_got !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rsp got ls/if=%b%b err=%b rdata=%h cyc=%0d want ls/if=%b err=%b rdata=%h cyc=%0d",
                                 bus.ls_rvalid_o, bus.if_rvalid_o, err_got, data_got, cyc, rv_exp, e.err, e.data, e.due);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // kind: 0 normal response expected, 1 no response expected, 2 timeout error expected
    task automatic do_fetch(input logic [31:0] a, input bit flush_gnt, input int kind, output int gcyc);
        int n = 0;
        exp_t e;
        bus.if_addr_i  = a;
        bus.if_flush_i = flush_gnt;
        bus.if_req_i   = 1'b1;
        @(negedge clk);
        while (!bus.if_gnt_o && n < 50) begin @(negedge clk); n++; end
        gcyc = cyc;
        checks++;
        if (!bus.if_gnt_o) begin
            failures++;
            $display("FAIL if_gnt_timeout addr=%h got gnt=0 required=1", a);
        end else if (bus.sram_req_o !== 1'b1 || bus.sram_we_o !== 1'b0 || bus.sram_addr_o !== a) begin
            failures++;
            $display("FAIL if_cmd got req=%b we=%b addr=%h required 1 0 %h", bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, a);
        end
        if (bus.if_gnt_o && kind == 0) begin
            e = '{is_ls: 1'b0, err: 1'b0, data: ref_rd(a), due: gcyc + sram_lat};
            sb.push_back(e);
        end else if (bus.if_gnt_o && kind == 2) begin
            e = '{is_ls: 1'b0, err: 1'b1, data: 32'h0, due: gcyc + TMO};
            sb.push_back(e);
        end
        tick();
        bus.if_req_i   = 1'b0;
        bus.if_flush_i = 1'b0;
    endtask

    task automatic do_ls(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input int kind, output int gcyc);
        int n = 0;
        exp_t e;
        bus.ls_we_i    = we;
        bus.ls_addr_i  = a;
        bus.ls_wdata_i = wd;
        bus.ls_be_i    = be;
        bus.ls_req_i   = 1'b1;
        @(negedge clk);
        while (!bus.ls_gnt_o && n < 50) begin @(negedge clk); n++; end
        gcyc = cyc;
        checks++;
        if (!bus.ls_gnt_o) begin
            failures++;
            $display("FAIL ls_gnt_timeout addr=%h got gnt=0 required=1", a);
        end else if (bus.sram_req_o !== 1'b1 || bus.sram_we_o !== we || bus.sram_addr_o !== a ||
                     (we && (bus.sram_wdata_o !== wd || bus.sram_be_o !== be))) begin
            failures++;
            $display("FAIL ls_cmd got req=%b we=%b addr=%h wdata=%h be=%b required we=%b addr=%h wdata=%h be=%b",
                     bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o, bus.sram_be_o, we, a, wd, be);
        end
        if (bus.ls_gnt_o && kind == 0) begin
            e = '{is_ls: 1'b1, err: 1'b0, data: we ? 32'h0 : ref_rd(a), due: gcyc + sram_lat};
            sb.push_back(e);
            if (we) ref_mem[a] = merge(ref_rd(a), wd, be);
        end else if (bus.ls_gnt_o && kind == 2) begin
            e = '{is_ls: 1'b1, err: 1'b1, data: 32'h0, due: gcyc + TMO};
            sb.push_back(e);
        end
        tick();
        bus.ls_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req_i = 1'b1;
        bus.ls_req_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.if_gnt_o, bus.ls_gnt_o, bus.sram_req_o, bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_err_o, bus.ls_err_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got gnt=%b%b req=%b rv=%b%b err=%b%b required all 0", bus.if_gnt_o, bus.ls_gnt_o,
                     bus.sram_req_o, bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_err_o, bus.ls_err_o);
        end
        checks++;
        if (bus.sram_addr_o !== 32'h0 || bus.if_rdata_o !== 32'h0 || bus.ls_rdata_o !== 32'h0 || bus.sram_we_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got addr=%h if_rdata=%h ls_rdata=%h required 0", bus.sram_addr_o, bus.if_rdata_o, bus.ls_rdata_o);
        end
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.if_gnt_o, bus.ls_gnt_o, bus.sram_req_o} !== 3'b0) begin
            failures++;
            $display("FAIL idle_no_req got gnt=%b%b req=%b required 000", bus.if_gnt_o, bus.ls_gnt_o, bus.sram_req_o);
        end
        tick();
    endtask

    task automatic test_fetch();
        int g;
        mem[32'h10] = 32'h0000_0013;
        ref_mem[32'h10] = 32'h0000_0013;
        sram_lat = 1;
        do_fetch(32'h10, 1'b0, 0, g);
        do_fetch(32'h14, 1'b0, 0, g);
        wait_to(g + 3);
        tick();
    endtask

    task automatic test_load_store();
        int g;
        sram_lat = 2;
        do_ls(1'b1, 32'h40, 32'hCAFE_F00D, 4'b1111, 0, g);
        do_ls(1'b1, 32'h40, 32'h1111_2222, 4'b0010, 0, g);
        do_ls(1'b0, 32'h40, 32'h0, 4'b0000, 0, g);
        do_ls(1'b0, 32'h80, 32'h0, 4'b0000, 0, g);
        wait_to(g + 3);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] want;
        exp_t e;
        sram_lat = 1;
        bus.ls_we_i   = 1'b0;
        bus.ls_addr_i = 32'h100;
        bus.if_addr_i = 32'h200;
        bus.ls_req_i  = 1'b1;
        bus.if_req_i  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            want = (i % (STV + 1) == STV) ? 3'b110 : 3'b101;
            checks++;
            if ({bus.sram_req_o, bus.if_gnt_o, bus.ls_gnt_o} !== want) begin
                failures++;
                $display("FAIL b2b_grant idx=%0d got req/if/ls=%b required %b", i, {bus.sram_req_o, bus.if_gnt_o, bus.ls_gnt_o}, want);
            end
            e = '{is_ls: want[0], err: 1'b0, data: want[0] ? ref_rd(32'h100) : ref_rd(32'h200), due: cyc + 1};
            sb.push_back(e);
            tick();
        end
        bus.ls_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        int g;
        sram_lat = 3;
        // flush in the cycle after the grant
        do_fetch(32'h20, 1'b0, 1, g);
        bus.if_flush_i = 1'b1;
        tick();
        bus.if_flush_i = 1'b0;
        wait_to(g + 3);
        checks++;
        if (bus.if_rvalid_o !== 1'b0 || bus.if_gnt_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_wait got rvalid=%b gnt=%b required 0 0", bus.if_rvalid_o, bus.if_gnt_o);
        end
        tick();
        do_fetch(32'h24, 1'b0, 0, g);
        wait_to(g + 3);
        tick();
        // flush in the grant cycle
        do_fetch(32'h28, 1'b1, 1, g);
        wait_to(g + 3);
        checks++;
        if (bus.if_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_gnt got rvalid=%b required 0", bus.if_rvalid_o);
        end
        tick();
        // flush in the ack cycle
        do_fetch(32'h2C, 1'b0, 1, g);
        wait_to(g + 2);
        tick();
        bus.if_flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.if_rvalid_o !== 1'b0 || bus.sram_ack_i !== 1'b1) begin
            failures++;
            $display("FAIL flush_ack got rvalid=%b ack=%b required 0 1", bus.if_rvalid_o, bus.sram_ack_i);
        end
        tick();
        bus.if_flush_i = 1'b0;
        // flush while the LSU owns the bus has no effect
        do_ls(1'b0, 32'h44, 32'h0, 4'b0000, 0, g);
        bus.if_flush_i = 1'b1;
        tick();
        bus.if_flush_i = 1'b0;
        wait_to(g + 4);
        // flush in IDLE has no effect on a following fetch
        tick();
        bus.if_flush_i = 1'b1;
        tick();
        bus.if_flush_i = 1'b0;
        do_fetch(32'h30, 1'b0, 0, g);
        wait_to(g + 4);
        tick();
    endtask

    task automatic test_timeout();
        int g;
        sram_mute = 1'b1;
        do_ls(1'b1, 32'h300, 32'h1234_5678, 4'b1111, 2, g);
        wait_to(g + 16);
        sram_mute = 1'b0;
        inject_ack = 1'b1;
        wait_to(g + 17);
        checks++;
        if ({bus.sram_ack_i, bus.ls_rvalid_o, bus.if_rvalid_o, bus.sram_req_o} !== 4'b1000) begin
            failures++;
            $display("FAIL idle_ack got ack/ls_rv/if_rv/req=%b required 1000",
                     {bus.sram_ack_i, bus.ls_rvalid_o, bus.if_rvalid_o, bus.sram_req_o});
        end
        tick();
        sram_lat = 1;
        do_ls(1'b0, 32'h300, 32'h0, 4'b0000, 0, g);
        sram_mute = 1'b1;
        do_fetch(32'h34, 1'b0, 2, g);
        wait_to(g + 16);
        sram_mute = 1'b0;
        tick();
    endtask

    task automatic test_reset_inflight();
        int g;
        sram_lat = 4;
        do_ls(1'b0, 32'h400, 32'h0, 4'b0000, 1, g);
        @(posedge clk); #3;
        rst = 1'b1;
        bus.ls_req_i = 1'b1;
        #1;
        checks++;
        if ({bus.if_gnt_o, bus.ls_gnt_o, bus.sram_req_o, bus.sram_we_o, bus.if_rvalid_o, bus.ls_rvalid_o,
             bus.if_err_o, bus.ls_err_o} !== 8'b0 || bus.sram_addr_o !== 32'h0 || bus.ls_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_inflight got gnt=%b%b req=%b rv=%b%b addr=%h required all 0", bus.if_gnt_o, bus.ls_gnt_o,
                     bus.sram_req_o, bus.if_rvalid_o, bus.ls_rvalid_o, bus.sram_addr_o);
        end
        tick();
        bus.ls_req_i = 1'b0;
        tick();
        rst = 1'b0;
        wait_to(g + 4);
        checks++;
        if (bus.sram_ack_i !== 1'b1 || bus.ls_rvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL late_ack got ack=%b ls_rvalid=%b required 1 0", bus.sram_ack_i, bus.ls_rvalid_o);
        end
        tick();
        sram_lat = 1;
        do_fetch(32'h38, 1'b0, 0, g);
        wait_to(g + 2);
        tick();
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf();
        exp_t e;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        sram_lat = 2;
        bus.ls_we_i   = 1'b0;
        bus.ls_addr_i = 32'h500;
        bus.if_addr_i = 32'h600;
        bus.ls_req_i  = 1'b1;
        bus.if_req_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.if_gnt_o, bus.ls_gnt_o} !== {1'b0, (i % 2 == 0)}) begin
                failures++;
                $display("FAIL perf_grant idx=%0d got if/ls=%b%b required 0%b", i, bus.if_gnt_o, bus.ls_gnt_o, (i % 2 == 0));
            end
            if (i % 2 == 0) begin
                e = '{is_ls: 1'b1, err: 1'b0, data: ref_rd(32'h500), due: cyc + 2};
                sb.push_back(e);
            end
            tick();
        end
        bus.ls_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        repeat (4) tick();
        checks++;
        if (perf_if !== 32'd6 || perf_ls !== 32'd3) begin
            failures++;
            $display("FAIL perf_cnt got if=%0d ls=%0d required 6 3", perf_if, perf_ls);
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.if_flush_i = 1'b0;
        bus.ls_req_i   = 1'b0;
        bus.ls_we_i    = 1'b0;
        bus.ls_addr_i  = '0;
        bus.ls_wdata_i = '0;
        bus.ls_be_i    = '0;
        test_reset();
        test_fetch();
        test_load_store();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_inflight();
`ifdef ARB_PERF_CNT_EN
        test_perf();
`endif
        repeat (20) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending responses required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
